// File: rtl/dmem_access_unit.sv
// Data-memory access unit: sub-word loads with extension, SB/SH read-modify-write, stall handshake.
// Optional macro DMEM_BYTE_ENABLE_EN adds dm_be and turns SB/SH into single-cycle masked writes.
module dmem_access_unit #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        mem_type,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              mem_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_re,
    output logic              dm_we,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
`ifdef DMEM_BYTE_ENABLE_EN
    ,
    output logic [3:0]        dm_be
`endif
);

    localparam logic [2:0] T_B  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_W  = 3'b010;
    localparam logic [2:0] T_BU = 3'b100;
    localparam logic [2:0] T_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_DATA = 2'd1,
        S_RMW_MERGE = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_rdata;

    logic        w_req;
    logic        w_misalign;
    logic        w_bad_type;
    logic        w_err;
    logic        w_go;
    logic        w_is_sw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;
    logic        w_unused;

    assign dm_addr  = addr[ADDR_W+1:2];
    assign rdata    = r_rdata;
    assign w_unused = ^{addr[31:ADDR_W+2]};

    // Request classification: errors win over any RAM access.
    always_comb begin
        w_req      = mem_read | mem_write;
        w_misalign = ((mem_type[1:0] == 2'b01) && addr[0])
                   || ((mem_type == T_W) && (addr[1:0] != 2'b00));
        w_bad_type = (mem_type == 3'b011) || (mem_type[2:1] == 2'b11)
                   || (mem_write && mem_type[2]);
        w_err      = w_req && ((mem_read && mem_write) || w_misalign || w_bad_type);
        w_go       = w_req && !w_err;
        w_is_sw    = mem_type == T_W;
    end

    // Lane extraction and sign/zero extension of the returned RAM word.
    always_comb begin
        w_byte     = 8'h00;
        w_half     = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        w_load_val = dm_rdata;
        case (addr[1:0])
            2'd0:    w_byte = dm_rdata[7:0];
            2'd1:    w_byte = dm_rdata[15:8];
            2'd2:    w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
        case (mem_type)
            T_B:     w_load_val = {{24{w_byte[7]}}, w_byte};
            T_BU:    w_load_val = {24'h000000, w_byte};
            T_H:     w_load_val = {{16{w_half[15]}}, w_half};
            T_HU:    w_load_val = {16'h0000, w_half};
            default: w_load_val = dm_rdata;
        endcase
    end

    // Merge store lane(s) into the word read back for SB/SH.
    always_comb begin
        w_merged = dm_rdata;
        if (mem_type == T_B) begin
            case (addr[1:0])
                2'd0:    w_merged[7:0]   = wdata[7:0];
                2'd1:    w_merged[15:8]  = wdata[7:0];
                2'd2:    w_merged[23:16] = wdata[7:0];
                default: w_merged[31:24] = wdata[7:0];
            endcase
        end else if (addr[1]) begin
            w_merged[31:16] = wdata[15:0];
        end else begin
            w_merged[15:0] = wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go && mem_read) begin
                    w_state_nxt = S_LOAD_DATA;
                end else if (w_go && !w_is_sw) begin
`ifdef DMEM_BYTE_ENABLE_EN
                    w_state_nxt = S_IDLE;
`else
                    w_state_nxt = S_RMW_MERGE;
`endif
                end
            end
            S_LOAD_DATA: w_state_nxt = S_DONE;
            S_RMW_MERGE: w_state_nxt = S_DONE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        mem_err  = 1'b0;
        dm_re    = 1'b0;
        dm_we    = 1'b0;
        dm_wdata = 32'h0000_0000;
`ifdef DMEM_BYTE_ENABLE_EN
        dm_be    = 4'b0000;
`endif
        case (r_state)
            S_IDLE: begin
                mem_err = w_err;
                if (w_go && mem_read) begin
                    dm_re = 1'b1;
                    stall = 1'b1;
                end else if (w_go && w_is_sw) begin
                    dm_we    = 1'b1;
                    dm_wdata = wdata;
`ifdef DMEM_BYTE_ENABLE_EN
                    dm_be    = 4'b1111;
`endif
                end else if (w_go) begin
`ifdef DMEM_BYTE_ENABLE_EN
                    // Masked write: replicate the store data so every lane carries it.
                    dm_we = 1'b1;
                    if (mem_type == T_B) begin
                        dm_wdata = {4{wdata[7:0]}};
                        dm_be    = 4'(4'b0001 << addr[1:0]);
                    end else begin
                        dm_wdata = {2{wdata[15:0]}};
                        dm_be    = addr[1] ? 4'b1100 : 4'b0011;
                    end
`else
                    dm_re = 1'b1;
                    stall = 1'b1;
`endif
                end
            end
            S_LOAD_DATA: stall = 1'b1;
            S_RMW_MERGE: begin
                stall    = 1'b1;
                dm_we    = 1'b1;
                dm_wdata = w_merged;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= 32'h0000_0000;
        end else if (r_state == S_LOAD_DATA) begin
            r_rdata <= w_load_val;
        end
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Data-memory responder for the CPU's load/store controls (memRead, memWrite, memType = funct3). Sits between the execute stage and a single-port synchronous data RAM (1-cycle read latency, 32-bit words, no byte enables by default). Performs sub-word extraction with sign/zero extension and read-modify-write for SB/SH. Holds the pipeline via `stall` until each access completes.

## Interface
- `ADDR_W`, default 12: word-address width of the data RAM.
- `clk`  in  1  system clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `mem_read`  in  1  load request from control unit
- `mem_write`  in  1  store request from control unit
- `mem_type`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
- `addr`  in  32  byte address (ALU result)
- `wdata`  in  32  store data (rs2)
- `rdata`  out  32  extended load result, valid while state is DONE after a load
- `stall`  out  1  hold pipeline; CPU keeps all request inputs stable while high
- `mem_err`  out  1  one-cycle pulse: misaligned, illegal type, or read+write together
- `dm_addr`  out  ADDR_W  word address = `addr[ADDR_W+1:2]`
- `dm_re`  out  1  RAM read strobe
- `dm_we`  out  1  RAM write strobe
- `dm_wdata`  out  32  RAM write data
- `dm_rdata`  in  32  RAM read data, valid the cycle after `dm_re`
- `dm_be`  out  4  byte enables (only with `DMEM_BYTE_ENABLE_EN`)

## Operation
- FSM states: IDLE, LOAD_DATA, RMW_MERGE, DONE.
- IDLE, no request: all strobes 0, `stall`=0.
- IDLE, error check first: H/HU with `addr[0]`=1, W with `addr[1:0]`≠0, `mem_type` in {011,110,111} (or ≥011 on store), or `mem_read`&`mem_write` → `mem_err`=1 for this cycle, no RAM strobe, `stall`=0, stay IDLE.
- Load: IDLE asserts `dm_re`, `stall`=1 → LOAD_DATA. LOAD_DATA: select byte `addr[1:0]` / half `addr[1]` of `dm_rdata`, sign-extend (B,H) or zero-extend (BU,HU, W passthrough), register into `rdata`; `stall`=1 → DONE.
- SW: IDLE asserts `dm_we`, `dm_wdata`=`wdata`, `stall`=0; single cycle, stays IDLE.
- SB/SH: IDLE asserts `dm_re`, `stall`=1 → RMW_MERGE. RMW_MERGE: `dm_we`=1, `dm_wdata` = `dm_rdata` with selected lane(s) replaced by `wdata[7:0]`/`wdata[15:0]`; `stall`=1 → DONE.
- DONE: `stall`=0, no strobes; unconditionally → IDLE (CPU advances this cycle, so the same request is never re-issued).
- `rdata` holds its last value outside DONE; `dm_addr` is combinational from `addr` in all states.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, `rdata`=0, `stall`=0, `mem_err`=0, `dm_re`=0, `dm_we`=0, `dm_wdata`=0.
- Reset mid-operation: return to IDLE; a pending RMW is aborted with no write if reset lands at or before the RMW_MERGE edge.
- `stall`, `dm_re`, `dm_we`, `dm_wdata`, `mem_err` are combinational from state and inputs.
- Load: 3 cycles request-to-release (stall high 2 cycles); `rdata` valid in DONE.
- SB/SH: 3 cycles (stall 2), write issued in cycle 2. SW: 1 cycle, no stall.
- Error: 1 cycle, no stall.

## Configuration
- `DMEM_BYTE_ENABLE_EN` defined: `dm_be` port exists; SB/SH complete like SW in one cycle with `dm_be` = lane mask (SB 0001<<`addr[1:0]`, SH 0011/1100), `dm_wdata` = store data replicated across lanes; RMW_MERGE unreachable. SW drives `dm_be`=1111; loads/idle drive 0000.
- Undefined: no `dm_be` port; sub-word stores use the read-modify-write sequence.

## Test plan
- LB at addr 0x103, RAM word 0x80FF_1234 → `dm_addr`=0x040, stall 2 cycles, DONE `rdata`=0xFFFF_FF80; same with LBU → 0x0000_0080.
- LH at 0x102, word 0x8001_7FFF → `rdata`=0xFFFF_8001; LW at 0x100 → 0x8001_7FFF.
- SB 0xAB at 0x101 over word 0x1122_3344 → one write of 0x1122_AB44 in cycle 2; with macro: single-cycle write, `dm_be`=0010, `dm_wdata`=0xABAB_ABAB.
- SW 0xDEAD_BEEF at 0x10 → `dm_we`=1 same cycle, `stall`=0, `dm_addr`=0x004.
- LW at 0x102, SH at 0x001, mem_type 011, read+write together → `mem_err`=1 one cycle, no `dm_re`/`dm_we`, `stall`=0.
- rst_n low in RMW_MERGE-entry cycle of SH → no `dm_we`, all outputs at reset values next cycle, next LW serviced normally.
